fft_out_reorder: RTL
====================

// Module: fft_out_reorder
// PURPOSE
//  Output stage placed directly downstream of topfft; consumes its 4-lane parallel output.
//  - Input bins arrive in bit-reversed order, 4 complex samples per valid beat.
//  - Emits each frame in natural bin order, 4 bins per cycle, using a ping-pong (2-bank) buffer.
//  - Optionally rounds/saturates the widened FFT data down to the system output width.
// PARAMETERS
//  NBITS      21   width of each real/imag part at input (topfft stage output width)
//  NBITS_OUT  10   width of each real/imag part at output
//  N          128  FFT points per frame (power of 2, >=8)
//  LOG2N      7    log2(N)
// PORTS
//  clk            in   1            clock, rising edge
//  rst            in   1            asynchronous, active-low reset
//  in_enable      in   1            input beat valid
//  fftIn0_up      in   2*NBITS      lane0 {re,im}, two's complement, re in MSBs
//  fftIn0_down    in   2*NBITS      lane1
//  fftIn1_up      in   2*NBITS      lane2
//  fftIn1_down    in   2*NBITS      lane3
//  o_enable       out  1            output beat valid
//  o_frame_start  out  1            high with first output beat of each frame (bins 0..3)
//  fftOut0_up     out  2*NBITS_OUT  bin 4c+0 {re,im}
//  fftOut0_down   out  2*NBITS_OUT  bin 4c+1
//  fftOut1_up     out  2*NBITS_OUT  bin 4c+2
//  fftOut1_down   out  2*NBITS_OUT  bin 4c+3
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0; write/read counters 0; bank select 0; read FSM IDLE.
//    Buffer contents are not cleared; a partial frame in progress is discarded.
//  - Write side: wr_cnt (LOG2N-2 bits) counts in_enable beats, 0..N/4-1, then wraps.
//    - Beat c, lane l holds bin k = bitrev_LOG2N(4c+l); it is stored at address k of the write bank.
//    - Gaps (in_enable=0) are allowed anywhere; wr_cnt holds during a gap.
//    - Beat N/4-1 completes the frame: write bank toggles and a frame_ready pulse is raised.
//  - Read FSM, 2 states:
//    - IDLE -> READ on frame_ready; read bank = the just-completed bank.
//    - READ: rd_cnt c=0..N/4-1, one beat per cycle, no gaps; lane l = bin 4c+l.
//    - READ -> IDLE after c=N/4-1, unless frame_ready is high in that same cycle;
//      then restart at c=0 on the other bank. Back-to-back frames give contiguous output.
//  - Latency: first o_enable occurs 2 clocks after the edge that samples the last input beat
//    (1 clock RAM read + 1 clock output register). o_frame_start coincides with c=0.
//  - Overlap: a frame is written in >=N/4 cycles, so a readout always ends before the next
//    frame completes. No backpressure; the ping-pong buffer never overruns.
//  - Outputs are registered and hold their last value while o_enable=0.
// CONFIGURATION
//  FFT_OUT_SAT_EN defined:
//    - Each re/im part: add 2^(S-1), arithmetic shift right by S=NBITS-NBITS_OUT
//      (round half up), then saturate to [-2^(NBITS_OUT-1), 2^(NBITS_OUT-1)-1].
//    - Rounding/saturation adds 1 pipeline register, so latency is 3.
//  FFT_OUT_SAT_EN undefined:
//    - Data passes unchanged; latency is 2.
//    - NBITS_OUT must equal NBITS; any other value is an elaboration error.
// TESTING (N=128, NBITS=21; NBITS_OUT=10 with macro, 21 without)
//  1. Hold rst=0 with random inputs -> all outputs 0, o_enable=0; release rst -> outputs stay 0.
//  2. One frame, 32 contiguous beats, bin k = {re=k, im=-k} placed at bitrev positions
//     -> 32 contiguous o_enable beats; beat c lanes = bins 4c..4c+3; o_frame_start on c=0 only.
//     Without macro: first beat 2 clocks after the last input beat.
//  3. Two back-to-back frames (64 contiguous beats; frame2 bin k = {re=200+k, im=0})
//     -> 64 contiguous output beats, no gap; frame2 values correct; 2 o_frame_start pulses.
//  4. in_enable alternating 1/0 across a frame -> output burst still 32 contiguous beats,
//     starting 2 clocks after the 32nd valid beat.
//  5. Pulse rst low after beat 10 of a frame, then send a full new frame
//     -> no output for the aborted frame; new frame reordered correctly.
//  6. FFT_OUT_SAT_EN, bin0 re = 1024, 2^20-1, -2^20, -1025 -> out re = 1, 511, -512, -1.

Source files
------------

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder of 4-lane bit-reversed FFT output into natural bin order
// Optional round-half-up/saturate to NBITS_OUT: define FFT_OUT_SAT_EN
module fft_out_reorder #(
  parameter int NBITS     = 21,
`ifdef FFT_OUT_SAT_EN
  parameter int NBITS_OUT = 10,
`else
  parameter int NBITS_OUT = 21,
`endif
  parameter int N         = 128,
  parameter int LOG2N     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enable,
  input  logic [2*NBITS-1:0]     fftIn0_up,
  input  logic [2*NBITS-1:0]     fftIn0_down,
  input  logic [2*NBITS-1:0]     fftIn1_up,
  input  logic [2*NBITS-1:0]     fftIn1_down,
  output logic                   o_enable,
  output logic                   o_frame_start,
  output logic [2*NBITS_OUT-1:0] fftOut0_up,
  output logic [2*NBITS_OUT-1:0] fftOut0_down,
  output logic [2*NBITS_OUT-1:0] fftOut1_up,
  output logic [2*NBITS_OUT-1:0] fftOut1_down
);

  localparam int CW = LOG2N - 2;
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [2*NBITS-1:0] din [4];
  logic [2*NBITS-1:0] mem [2*N];
  logic [2*NBITS-1:0] rd_data [4];
  logic [2*NBITS_OUT-1:0] q_data [4];
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          wr_bank, rd_bank;
  logic          frame_ready;
  logic          rd_vld, rd_first;
  logic          q_vld, q_first;
  state_t        state;

  assign din[0] = fftIn0_up;
  assign din[1] = fftIn0_down;
  assign din[2] = fftIn1_up;
  assign din[3] = fftIn1_down;

  // The last beat of a frame is recognised in the same cycle it arrives so readout can start at once
  assign frame_ready = in_enable && (wr_cnt == CNT_LAST);

  // Scatter the four lanes of each beat to their bit-reversed bin addresses in the write bank
  always_ff @(posedge clk) begin
    if (in_enable) begin
      for (int l = 0; l < 4; l++) mem[{wr_bank, bitrev({wr_cnt, 2'(l)})}] <= din[l];
    end
  end

  // Write beat counter; the bank flips when a frame completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_enable) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_ready) wr_bank <= ~wr_bank;
    end
  end

  // Read FSM: sweep the completed bank, chaining straight into the next bank when it is ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      rd_vld   <= (state == READ);
      rd_first <= (state == READ) && (rd_cnt == '0);
      case (state)
        IDLE: begin
          if (frame_ready) begin
            state   <= READ;
            rd_cnt  <= '0;
            rd_bank <= wr_bank;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == CNT_LAST) begin
            if (frame_ready) rd_bank <= wr_bank;
            else             state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered buffer read of four consecutive natural-order bins
  always_ff @(posedge clk) begin
    if (state == READ) begin
      for (int l = 0; l < 4; l++) rd_data[l] <= mem[{rd_bank, rd_cnt, 2'(l)}];
    end
  end

`ifdef FFT_OUT_SAT_EN
  localparam int S = NBITS - NBITS_OUT;

  function automatic logic [NBITS_OUT-1:0] round_sat(input logic [NBITS-1:0] x);
    logic [NBITS:0]     half;
    logic [NBITS:0]     sum;
    logic [NBITS_OUT:0] sh;
    half      = '0;
    half[S-1] = 1'b1;
    sum       = {x[NBITS-1], x} + half;
    sh        = sum[NBITS:S];
    if (sh[NBITS_OUT] != sh[NBITS_OUT-1])
      return {sh[NBITS_OUT], {(NBITS_OUT-1){~sh[NBITS_OUT]}}};
    return sh[NBITS_OUT-1:0];
  endfunction

  // Extra stage that rounds and saturates each re/im part
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld   <= 1'b0;
      q_first <= 1'b0;
      for (int l = 0; l < 4; l++) q_data[l] <= '0;
    end else begin
      q_vld   <= rd_vld;
      q_first <= rd_first;
      if (rd_vld) begin
        for (int l = 0; l < 4; l++)
          q_data[l] <= {round_sat(rd_data[l][2*NBITS-1:NBITS]), round_sat(rd_data[l][NBITS-1:0])};
      end
    end
  end
`else
  if (NBITS_OUT != NBITS) begin : g_width_check
    $error("NBITS_OUT must equal NBITS when FFT_OUT_SAT_EN is not defined");
  end

  // Pass-through: data feeds the output register unchanged
  always_comb begin
    q_vld   = rd_vld;
    q_first = rd_first;
    for (int l = 0; l < 4; l++) q_data[l] = rd_data[l];
  end
`endif

  // Output register; data holds its last value while no beat is valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_enable      <= 1'b0;
      o_frame_start <= 1'b0;
      fftOut0_up    <= '0;
      fftOut0_down  <= '0;
      fftOut1_up    <= '0;
      fftOut1_down  <= '0;
    end else begin
      o_enable      <= q_vld;
      o_frame_start <= q_vld && q_first;
      if (q_vld) begin
        fftOut0_up   <= q_data[0];
        fftOut0_down <= q_data[1];
        fftOut1_up   <= q_data[2];
        fftOut1_down <= q_data[3];
      end
    end
  end

endmodule
